// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: default widths, ALU select
// encoding and the saturating counter helper.
package id_ex_stage_pkg;

    localparam int XLEN    = 64;
    localparam int RIDX    = 5;
    localparam int SEL_W   = 3;
    localparam int SHAMT_W = 6;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_OR    = 3'd2,
        ALU_XNOR  = 3'd3,
        ALU_AND   = 3'd4,
        ALU_CMP   = 3'd5,
        ALU_SHIFT = 3'd6,
        ALU_ZERO  = 3'd7
    } alu_sel_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one ALU source: EX/MEM result beats writeback data,
// which beats the value read from the register file in decode.
module fwd_mux #(
    parameter int XLEN = id_ex_stage_pkg::XLEN,
    parameter int RIDX = id_ex_stage_pkg::RIDX
) (
    input  logic [RIDX-1:0] src_idx,
    input  logic [XLEN-1:0] src_val,
    input  logic            exm_valid,
    input  logic            exm_reg_write,
    input  logic            exm_is_load,
    input  logic [RIDX-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    logic exm_hit;
    logic wb_hit;

    // A load in EX/MEM has no data yet; its consumer is held back by the hazard stall.
    assign exm_hit = exm_valid && exm_reg_write && !exm_is_load
                     && (exm_rd != '0) && (exm_rd == src_idx);
    assign wb_hit  = wb_valid && wb_reg_write
                     && (wb_rd != '0) && (wb_rd == src_idx);

    always_comb begin
        operand = src_val;
        if (exm_hit) begin
            operand = exm_result;
        end else if (wb_hit) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/load-use control, a saturating
// stall-cycle counter and combinational operand forwarding into EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = id_ex_stage_pkg::XLEN,
    parameter int RIDX = id_ex_stage_pkg::RIDX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RIDX-1:0]    id_rs1,
    input  logic [RIDX-1:0]    id_rs2,
    input  logic [XLEN-1:0]    id_rs1_val,
    input  logic [XLEN-1:0]    id_rs2_val,
    input  logic [RIDX-1:0]    id_rd,
    input  logic               id_reg_write,
    input  logic               id_is_load,
    input  logic [SEL_W-1:0]   id_sel,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic               exm_valid,
    input  logic               exm_reg_write,
    input  logic               exm_is_load,
    input  logic [RIDX-1:0]    exm_rd,
    input  logic [XLEN-1:0]    exm_result,
    input  logic               wb_valid,
    input  logic               wb_reg_write,
    input  logic [RIDX-1:0]    wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    input  logic               ex_hold,
    output logic [XLEN-1:0]    ex_A,
    output logic [XLEN-1:0]    ex_B,
    output logic [SEL_W-1:0]   ex_sel,
    output logic [SHAMT_W-1:0] ex_shamt,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_is_load,
    output logic [RIDX-1:0]    ex_rd,
    output logic               stall_id,
    output logic [31:0]        stall_cnt
);

    logic               valid_q;
    logic [RIDX-1:0]    rs1_q;
    logic [RIDX-1:0]    rs2_q;
    logic [XLEN-1:0]    rs1_val_q;
    logic [XLEN-1:0]    rs2_val_q;
    logic [RIDX-1:0]    rd_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               reg_write_q;
    logic               is_load_q;
    logic [31:0]        stall_cnt_q;
    logic               load_use;

    assign load_use = valid_q && is_load_q && reg_write_q && (rd_q != '0)
                      && id_valid && ((id_rs1 == rd_q) || (id_rs2 == rd_q));

    // NOTE: stall_id is gated by rst_n so a held or hazarding slot cannot leak a stall through reset.
    assign stall_id = rst_n && !flush && (ex_hold || load_use);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            rd_q        <= '0;
            sel_q       <= '0;
            shamt_q     <= '0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (stall_id) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!ex_hold) begin
                if (load_use) begin
                    // Bubble: the load leaves EX, so the match clears after one cycle.
                    valid_q <= 1'b0;
                end else begin
                    valid_q     <= id_valid;
                    rs1_q       <= id_rs1;
                    rs2_q       <= id_rs2;
                    rs1_val_q   <= id_rs1_val;
                    rs2_val_q   <= id_rs2_val;
                    rd_q        <= id_rd;
                    sel_q       <= id_sel;
                    shamt_q     <= id_shamt;
                    reg_write_q <= id_reg_write;
                    is_load_q   <= id_is_load;
                end
            end
        end
    end

    fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_a (
        .src_idx       (rs1_q),
        .src_val       (rs1_val_q),
        .exm_valid     (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_is_load   (exm_is_load),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .operand       (ex_A)
    );

    fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_b (
        .src_idx       (rs2_q),
        .src_val       (rs2_val_q),
        .exm_valid     (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_is_load   (exm_is_load),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .operand       (ex_B)
    );

    assign ex_valid     = valid_q;
    assign ex_rd        = rd_q;
    assign ex_sel       = sel_q;
    assign ex_shamt     = shamt_q;
    assign ex_reg_write = valid_q && reg_write_q;
    assign ex_is_load   = valid_q && is_load_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter RIDX, default 5, register-index width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  decode slot holds an instruction.
REQ-006 id_rs1, id_rs2  in  RIDX each  source register indices.
REQ-007 id_rs1_val, id_rs2_val  in  XLEN each  register-file read data.
REQ-008 id_rd  in  RIDX  destination index; id_reg_write, id_is_load  in  1 each.
REQ-009 id_sel  in  3  ALU op select; id_shamt  in  6  shift amount.
REQ-010 exm_rd  in  RIDX; exm_valid, exm_reg_write, exm_is_load  in  1 each  EX/MEM slot (instruction whose ALU result is registered).
REQ-011 exm_result  in  XLEN  registered ALU output.
REQ-012 wb_valid, wb_reg_write  in  1 each; wb_rd  in  RIDX; wb_data  in  XLEN  writeback slot.
REQ-013 flush  in  1  squash instruction entering EX; ex_hold  in  1  downstream busy, freeze.
REQ-014 ex_A, ex_B  out  XLEN  forwarded ALU operands; ex_sel  out 3; ex_shamt  out 6.
REQ-015 ex_valid, ex_reg_write, ex_is_load  out 1 each; ex_rd  out  RIDX.
REQ-016 stall_id  out  1  freeze PC and IF/ID; stall_cnt  out  32  stall-cycle counter.

Function
REQ-017 Register fields (valid, rs1/rs2 idx, rs1/rs2 val, rd, sel, shamt, reg_write, is_load) SHALL update on clk rise per REQ-018..021 priority.
REQ-018 Priority 1: flush=1 -> ex_valid<=0, other fields don't-care, stall_id=0.
REQ-019 Priority 2: ex_hold=1 -> all fields hold; stall_id=1.
REQ-020 Priority 3: load-use hazard (ex_valid & ex_is_load & ex_reg_write & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd)) -> ex_valid<=0 (bubble), stall_id=1 combinationally same cycle.
REQ-021 Otherwise: capture all id_* fields; ex_valid<=id_valid.
REQ-022 ex_A SHALL = exm_result if exm_valid & exm_reg_write & !exm_is_load & exm_rd!=0 & exm_rd==stored rs1; else wb_data if wb_valid & wb_reg_write & wb_rd!=0 & wb_rd==stored rs1; else stored rs1_val. EX/MEM wins over WB.
REQ-023 ex_B SHALL follow REQ-022 with rs2.
REQ-024 Forwarding SHALL be combinational from register outputs; zero added latency; ex_* valid in the same cycle the ALU samples them.
REQ-025 Index 0 SHALL never be forwarded nor trigger hazard.
REQ-026 ex_sel, ex_shamt SHALL pass stored values unmodified; ex_sel=7 legal (ALU yields zero).
REQ-027 When ex_valid=0, ex_reg_write and ex_is_load outputs SHALL read 0.
REQ-028 stall_cnt SHALL increment on every cycle stall_id=1, saturating at 32'hFFFF_FFFF.
REQ-029 Hazard stall SHALL last exactly 1 cycle per load-use pair (bubble clears the match).

Reset
REQ-030 rst_n=0 SHALL immediately clear ex_valid, ex_rd, ex_sel, ex_shamt, stored values, stall_cnt to 0; stall_id=0.
REQ-031 Reset mid-stall or mid-hold SHALL abandon it; first post-reset edge behaves per REQ-021.

Structure
REQ-032 Shared package SHALL hold XLEN, RIDX, ALU select encoding (0 add,1 sub,2 or,3 xnor,4 and,5 compare,6 shift,7 zero).
REQ-033 One sub-module fwd_mux (operand forwarding, instanced twice for A and B) SHALL be used.

Verification
REQ-034 Reset: rst_n low mid-run -> all outputs 0 within same cycle, stall_cnt=0.
REQ-035 EX/MEM forward: exm_rd=3, exm_result=64'h55, stored rs1=3, rs1_val=64'h11, wb_rd=3 wb_data=64'h99 -> ex_A=64'h55.
REQ-036 WB forward and x0: wb_rd=4 wb_data=64'hAA, rs2=4 -> ex_B=64'hAA; repeat with rd=0 -> ex_B=stored val.
REQ-037 Load-use: EX holds load rd=5, id_rs1=5 -> stall_id=1 one cycle, ex_valid=0 next edge, stall_cnt+1, then instruction issues.
REQ-038 flush and ex_hold both 1 -> ex_valid=0 next edge; ex_hold alone for 3 cycles -> outputs constant, stall_cnt+3.
